// File: rtl/ahb_mem_slave.sv
// AHB-Lite slave memory: byte-lane storage, fixed wait states, two-cycle ERROR response.
// Optional build macro AHB_MEM_LFSR_WAIT_EN adds 0..3 pseudo-random extra wait cycles.
module ahb_mem_slave #(
  parameter int          AHB_DATA_WIDTH    = 64,
  parameter int          AHB_ADDRESS_WIDTH = 32,
  parameter int          MEM_DEPTH         = 1024,
  parameter int          WAIT_STATES       = 0,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [1:0]                   HTRANS,
  output logic                         HREADY,
  output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
  output logic                         HRESP,
  output logic                         HEXOKAY
);
  localparam int DW = AHB_DATA_WIDTH;
  localparam int AW = AHB_ADDRESS_WIDTH;
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [AW:0] MEM_BYTES = (AW+1)'(MEM_DEPTH * NB);

  typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            hready_q, hready_d;
  logic            hresp_q, hresp_d;
  logic [DW-1:0]   hrdata_q, hrdata_d;
  logic [IW-1:0]   word_q, word_d;
  logic [NB-1:0]   mask_q, mask_d;
  logic            write_q, write_d;
  logic            wr_pend_q, wr_pend_d;
  logic [DW-1:0]   mem [MEM_DEPTH];

  logic            accept, bad_addr, bad_size, bad_align, err, commit;
  logic [IW-1:0]   haddr_word;
  logic [AW-1:0]   align_mask;
  logic [NB-1:0]   size_ones, lane_mask;
  logic [DW-1:0]   rd_fwd;
  logic [4:0]      wait_n;

`ifdef AHB_MEM_LFSR_WAIT_EN
  logic [15:0] lfsr_q;
  logic        unused_burst;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign wait_n       = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};
  assign unused_burst = ^HBURST;
`else
  logic unused_cfg;
  assign wait_n     = 5'(WAIT_STATES);
  assign unused_cfg = ^{HBURST, LFSR_SEED};
`endif

  always_comb begin
    accept     = hready_q && HTRANS[1];
    haddr_word = HADDR[LB +: IW];
    bad_addr   = {1'b0, HADDR} >= MEM_BYTES;
    bad_size   = int'(HSIZE) > LB;
    align_mask = ~({AW{1'b1}} << HSIZE);
    bad_align  = |(HADDR & align_mask);
    err        = bad_addr | bad_size | bad_align;
    size_ones  = ~({NB{1'b1}} << (8'd1 << HSIZE));
    lane_mask  = size_ones << HADDR[LB-1:0];
    commit     = wr_pend_q && hready_q;
    // A read accepted on the edge a write commits must see the merged new lanes.
    rd_fwd     = mem[haddr_word];
    for (int b = 0; b < NB; b++) begin
      if (commit && (word_q == haddr_word) && mask_q[b]) rd_fwd[b*8 +: 8] = HWDATA[b*8 +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hready_d  = hready_q;
    hresp_d   = hresp_q;
    hrdata_d  = hrdata_q;
    word_d    = word_q;
    mask_d    = mask_q;
    write_d   = write_q;
    wr_pend_d = hready_q ? 1'b0 : wr_pend_q;
    case (state_q)
      ST_READY: begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        if (accept) begin
          word_d  = haddr_word;
          mask_d  = lane_mask;
          write_d = HWRITE;
          if (err) begin
            state_d  = ST_ERR1;
            hready_d = 1'b0;
            hresp_d  = 1'b1;
          end else begin
            wr_pend_d = HWRITE;
            if (wait_n != 5'd0) begin
              state_d  = ST_WAIT;
              cnt_d    = wait_n - 5'd1;
              hready_d = 1'b0;
            end else if (!HWRITE) begin
              hrdata_d = rd_fwd;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 5'd0) begin
          state_d  = ST_READY;
          hready_d = 1'b1;
          if (!write_q) hrdata_d = mem[word_q];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_ERR1: begin
        state_d  = ST_READY;
        hready_d = 1'b1;
        hresp_d  = 1'b1;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_READY;
      cnt_q     <= 5'd0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      hrdata_q  <= '0;
      word_q    <= '0;
      mask_q    <= '0;
      write_q   <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
      word_q    <= word_d;
      mask_q    <= mask_d;
      write_q   <= write_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Storage is never reset; a write pending at reset is dropped with wr_pend_q.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < NB; b++) begin
        if (mask_q[b]) mem[word_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  assign HREADY  = hready_q;
  assign HRESP   = hresp_q;
  assign HRDATA  = hrdata_q;
  assign HEXOKAY = 1'b0;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: one instance with zero wait states, one with three.
// Drivers push expected responses; a negedge monitor pops and compares at each completed data phase.
module tb_ahb_mem_slave;
  localparam int EW = 134;  // {resp, is_read, waits[3:0], lane_mask[63:0], data[63:0]}

  logic        clk, rst;
  logic [31:0] haddr  [2];
  logic [63:0] hwdata [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [1:0]  htrans [2];
  logic        hready [2];
  logic        hresp  [2];
  logic        hexokay[2];
  logic [63:0] hrdata [2];

  logic [EW-1:0] exp_q[2][$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ahb_mem_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr[0]), .HWDATA(hwdata[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HBURST(hburst[0]), .HTRANS(htrans[0]), .HREADY(hready[0]),
    .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HEXOKAY(hexokay[0]));

  ahb_mem_slave #(.WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr[1]), .HWDATA(hwdata[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HBURST(hburst[1]), .HTRANS(htrans[1]), .HREADY(hready[1]),
    .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HEXOKAY(hexokay[1]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // expected-response builders
  function automatic logic [3:0] waits_of(input int d);
    return (d == 0) ? 4'd0 : 4'd3;
  endfunction

  function automatic logic [EW-1:0] e_wr(input int d);
    return {1'b0, 1'b0, waits_of(d), 64'h0, 64'h0};
  endfunction

  function automatic logic [EW-1:0] e_err();
    return {1'b1, 1'b0, 4'd1, 64'h0, 64'h0};
  endfunction

  function automatic logic [EW-1:0] e_rd(input int d, input logic [31:0] a, input logic [2:0] sz,
                                         input logic [63:0] data);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++)
      if (b >= int'(a[2:0]) && b < int'(a[2:0]) + (1 << sz)) m[b*8 +: 8] = 8'hFF;
    return {1'b0, 1'b1, waits_of(d), m, data};
  endfunction

  // driver tasks: called #1 after a rising edge, return #1 after the accepting edge
  task automatic wait_accept(input int d);
    int   n;
    logic r;
    n = 0;
    do begin
      @(negedge clk);
      r = hready[d];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 40);
    if (!r) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: dut %0d HREADY stayed %b, expected 1", d, r);
    end
  endtask

  task automatic issue(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [1:0] tr, input logic [63:0] wd, input logic [EW-1:0] e);
    exp_q[d].push_back(e);
    haddr[d]  = a;
    hwrite[d] = w;
    hsize[d]  = sz;
    htrans[d] = tr;
    wait_accept(d);
    if (w) hwdata[d] = wd;
  endtask

  task automatic idle_end(input int d);
    htrans[d] = 2'b00;
    wait_accept(d);
  endtask

  // monitor / scoreboard
  logic          pend [2];
  int            lowc [2];
  logic [EW-1:0] e;

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    lowc[0] = 0;    lowc[1] = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend[d] = 1'b0;
        lowc[d] = 0;
        exp_q[d].delete();
      end else begin
        if (pend[d]) begin
          if (!hready[d]) begin
            lowc[d]++;
            if (exp_q[d].size() > 0) chk("hresp_wait", 64'(hresp[d]), 64'(exp_q[d][0][133]));
          end else begin
            if (exp_q[d].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL exp_underflow: dut %0d completed a transfer with no expectation", d);
            end else begin
              e = exp_q[d].pop_front();
              chk("hresp", 64'(hresp[d]), 64'(e[133]));
              chk("waits", 64'(lowc[d]), 64'(e[131:128]));
              if (e[132]) chk("rdata", hrdata[d] & e[127:64], e[63:0] & e[127:64]);
            end
            pend[d] = 1'b0;
            lowc[d] = 0;
          end
        end
        if (hready[d] && htrans[d][1]) pend[d] = 1'b1;
      end
    end
  end

  // stimulus
  int c0, c1;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      haddr[d] = '0; hwdata[d] = '0; hwrite[d] = 1'b0;
      hsize[d] = 3'd0; hburst[d] = 3'd0; htrans[d] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_hready", 64'(hready[d]), 64'd1);
        chk("rst_hresp", 64'(hresp[d]), 64'd0);
        chk("rst_hrdata", hrdata[d], 64'd0);
        chk("rst_hexokay", 64'(hexokay[d]), 64'd0);
      end
    end
    @(posedge clk); #1;

    // write then read, zero waits (read back-to-back, then again after idle)
    issue(0, 32'h40, 1'b1, 3'd3, 2'b10, 64'h0123456789ABCDEF, e_wr(0));
    issue(0, 32'h40, 1'b0, 3'd3, 2'b10, 64'h0, e_rd(0, 32'h40, 3'd3, 64'h0123456789ABCDEF));
    idle_end(0);
    issue(0, 32'h40, 1'b0, 3'd3, 2'b10, 64'h0, e_rd(0, 32'h40, 3'd3, 64'h0123456789ABCDEF));
    idle_end(0);

    // byte lanes: junk in unselected lanes must not land
    issue(0, 32'h80, 1'b1, 3'd3, 2'b10, 64'h0, e_wr(0));
    issue(0, 32'h83, 1'b1, 3'd0, 2'b10, 64'h1111_2222_5A44_5566, e_wr(0));
    issue(0, 32'h86, 1'b1, 3'd1, 2'b10, 64'hBEEF_7777_8888_9999, e_wr(0));
    issue(0, 32'h80, 1'b0, 3'd3, 2'b10, 64'h0, e_rd(0, 32'h80, 3'd3, 64'hBEEF_0000_5A00_0000));
    idle_end(0);
    issue(0, 32'h80, 1'b0, 3'd3, 2'b10, 64'h0, e_rd(0, 32'h80, 3'd3, 64'hBEEF_0000_5A00_0000));
    idle_end(0);

    // forwarding, plus a back-to-back pair on different words
    issue(0, 32'h10, 1'b1, 3'd0, 2'b10, 64'h0000_0000_0000_00AA, e_wr(0));
    issue(0, 32'h10, 1'b0, 3'd0, 2'b10, 64'h0, e_rd(0, 32'h10, 3'd0, 64'h0000_0000_0000_00AA));
    issue(0, 32'h18, 1'b1, 3'd3, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, e_wr(0));
    issue(0, 32'h10, 1'b0, 3'd0, 2'b10, 64'h0, e_rd(0, 32'h10, 3'd0, 64'h0000_0000_0000_00AA));
    idle_end(0);

    // errors: out of range, unaligned word, unaligned dword write, oversize; then OKAY, memory intact
    issue(0, 32'h2000, 1'b0, 3'd3, 2'b10, 64'h0, e_err());
    issue(0, 32'h0002, 1'b0, 3'd2, 2'b10, 64'h0, e_err());
    issue(0, 32'h0044, 1'b1, 3'd3, 2'b10, 64'hDEAD_DEAD_DEAD_DEAD, e_err());
    issue(0, 32'h0040, 1'b0, 3'd4, 2'b10, 64'h0, e_err());
    issue(0, 32'h0040, 1'b0, 3'd3, 2'b10, 64'h0, e_rd(0, 32'h40, 3'd3, 64'h0123456789ABCDEF));
    idle_end(0);

    // wait states: fill four words, then INCR4 read
    issue(1, 32'h100, 1'b1, 3'd3, 2'b10, 64'hA0A0_0000_0000_0001, e_wr(1));
    issue(1, 32'h108, 1'b1, 3'd3, 2'b11, 64'hA1A1_0000_0000_0002, e_wr(1));
    issue(1, 32'h110, 1'b1, 3'd3, 2'b11, 64'hA2A2_0000_0000_0003, e_wr(1));
    issue(1, 32'h118, 1'b1, 3'd3, 2'b11, 64'hA3A3_0000_0000_0004, e_wr(1));
    idle_end(1);
    hburst[1] = 3'b011;
    issue(1, 32'h100, 1'b0, 3'd3, 2'b10, 64'h0, e_rd(1, 32'h100, 3'd3, 64'hA0A0_0000_0000_0001));
    c0 = cyc;
    issue(1, 32'h108, 1'b0, 3'd3, 2'b11, 64'h0, e_rd(1, 32'h108, 3'd3, 64'hA1A1_0000_0000_0002));
    issue(1, 32'h110, 1'b0, 3'd3, 2'b11, 64'h0, e_rd(1, 32'h110, 3'd3, 64'hA2A2_0000_0000_0003));
    issue(1, 32'h118, 1'b0, 3'd3, 2'b11, 64'h0, e_rd(1, 32'h118, 3'd3, 64'hA3A3_0000_0000_0004));
    idle_end(1);
    c1 = cyc;
    hburst[1] = 3'b000;
    chk("incr4_cycles", 64'(c1 - c0), 64'd16);

    // error on the waited slave keeps two-cycle timing
    issue(1, 32'h104, 1'b0, 3'd3, 2'b10, 64'h0, e_err());
    issue(1, 32'h108, 1'b0, 3'd2, 2'b10, 64'h0, e_rd(1, 32'h108, 3'd2, 64'hA1A1_0000_0000_0002));
    idle_end(1);

    // reset during a waited write: nothing is committed
    issue(1, 32'h200, 1'b1, 3'd3, 2'b10, 64'h5555_5555_5555_5555, e_wr(1));
    idle_end(1);
    issue(1, 32'h200, 1'b1, 3'd3, 2'b10, 64'hAAAA_AAAA_AAAA_AAAA, e_wr(1));
    @(posedge clk); #1;
    rst = 1'b1;
    htrans[0] = 2'b00;
    htrans[1] = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_hready", 64'(hready[1]), 64'd1);
    chk("midrst_hresp", 64'(hresp[1]), 64'd0);
    chk("midrst_hrdata", hrdata[1], 64'd0);
    @(posedge clk); #1;
    issue(1, 32'h200, 1'b0, 3'd3, 2'b10, 64'h0, e_rd(1, 32'h200, 3'd3, 64'h5555_5555_5555_5555));
    idle_end(1);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q0_empty", 64'(exp_q[0].size()), 64'd0);
    chk("exp_q1_empty", 64'(exp_q[1].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Parametrised AHB-Lite slave memory model; successor to the fixed-response slave stub.
- Adds real storage, configurable wait states, byte-lane writes, and a two-cycle ERROR response for bad accesses.
- Sits on the AHB side of the bridge as the bench/system target. Serves SINGLE and all INCR/WRAP bursts beat by beat, using HADDR as presented.

Parameters:
AHB_DATA_WIDTH, 64, data bus width in bits (32/64/128); NB = AHB_DATA_WIDTH/8
AHB_ADDRESS_WIDTH, 32, address bus width
MEM_DEPTH, 1024, storage depth in AHB_DATA_WIDTH words (power of 2)
WAIT_STATES, 0, fixed HREADY-low cycles per OKAY data phase (0..15)
LFSR_SEED, 16'hACE1, nonzero seed for optional random waits

Ports:
HCLK  in  1  clock, rising edge
HRESET  in  1  asynchronous active-high reset
HADDR  in  AHB_ADDRESS_WIDTH  byte address (address phase)
HWDATA  in  AHB_DATA_WIDTH  write data (data phase)
HWRITE  in  1  1=write
HSIZE  in  3  transfer size, 2**HSIZE bytes
HBURST  in  3  burst type (informational only)
HTRANS  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
HREADY  out  1  transfer done / slave ready
HRDATA  out  AHB_DATA_WIDTH  read data, valid when HREADY=1 ending a read
HRESP  out  1  0=OKAY 1=ERROR
HEXOKAY  out  1  exclusive okay; always 0

Behaviour:
- Reset (async, HRESET=1): HREADY=1, HRESP=0, HRDATA=0, HEXOKAY=0, FSM=READY, wait counter=0, LFSR=LFSR_SEED. Memory is not cleared.
- Address phase is accepted at a rising edge with HREADY=1 and HTRANS in {NONSEQ,SEQ}. Latch addr, size, write, byte-lane mask.
- IDLE and BUSY get a zero-wait OKAY with no memory access.
- Error conditions, checked at acceptance:
  - HADDR >= MEM_DEPTH*NB
  - 2**HSIZE > NB
  - HADDR not aligned to 2**HSIZE
- FSM states: READY, WAIT, ERR1.
  - READY, accept OK, N>0: goto WAIT, counter=N-1, HREADY<=0.
  - READY, accept OK, N=0: stay READY, HREADY stays 1, data phase completes next cycle.
  - READY, accept error: goto ERR1, HREADY<=0, HRESP<=1.
  - WAIT: counter 0 -> goto READY, HREADY<=1. Otherwise decrement.
  - ERR1: goto READY, HREADY<=1, HRESP<=1. This is the second error cycle. HRESP returns to 0 after it unless another error is accepted.
- Address-phase signals seen while HREADY=0 are ignored; the master holds them.
- Read: HRDATA is loaded from mem[word] on the edge that drives HREADY=1 for that data phase (for N=0, the accept edge). Only the addressed lanes are meaningful; the others carry memory contents. HRDATA holds its value otherwise.
- Write: HWDATA lanes selected by the mask are committed on the edge ending the data phase (HREADY=1 sampled). An errored write commits nothing.
- Read-after-write hazard: a read accepted on the same edge a write commits to the same word returns the merged new lanes (forwarding is required).
- Lane mask: NB-bit, 2**HSIZE ones shifted by HADDR[log2(NB)-1:0].
- HBURST is not checked; WRAP addresses are taken from HADDR.
- Reset asserted mid-transfer: it aborts immediately to reset values; no memory write occurs.

Optional Feature:
AHB_MEM_LFSR_WAIT_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle. Each accepted OKAY transfer gets a wait count equal to WAIT_STATES + LFSR[1:0] (0..3 extra cycles). ERROR timing is unchanged.
- Undefined: the wait count is exactly WAIT_STATES; no LFSR logic is present.

Test Plan:
- Reset then idle: HRESET pulse, HTRANS=IDLE for 5 cycles -> HREADY=1, HRESP=0, HRDATA=0, HEXOKAY=0 throughout.
- Write then read, WAIT_STATES=0: write 64'h0123456789ABCDEF to 0x40, then read 0x40 -> HREADY never 0; read data equals the written value.
- Byte lanes: word 0x80 preloaded with 0, then byte write 8'h5A at 0x83 and halfword 16'hBEEF at 0x86 -> read 0x80 returns 64'hBEEF_0000_5A00_0000.
- Wait states, WAIT_STATES=3: INCR4 read at 0x100 -> each beat shows exactly 3 HREADY-low cycles; 4 beats complete in 16 data-phase cycles.
- Error: read at MEM_DEPTH*NB, then an unaligned word read at 0x2 -> each gives HREADY=0/HRESP=1 followed by HREADY=1/HRESP=1. The next valid transfer gets OKAY, and no memory change is observed.
- Forwarding: write 0xAA to byte 0x10, then a back-to-back byte read of 0x10 with WAIT_STATES=0 -> HRDATA[7:0]=0xAA.
